// File: rtl/wb_fifo_pkg.sv
// Shared types for the Wishbone byte FIFOs.
package wb_fifo_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_ACK,
    RESP_ERR
  } wb_resp_e;

endpackage

// File: rtl/fifo_addr_gen_an.sv
// Wrapping buffer pointer with increment enable and async active-low reset.
module fifo_addr_gen_an #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/wb_read_fifo.sv
// Read-direction Wishbone byte FIFO: pipelined controller fetches bytes from a
// source, pipelined device lets a consumer pop them.
module wb_read_fifo
  import wb_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_en_i,
  output logic                  src_cyc_o,
  output logic                  src_stb_o,
  output logic                  src_we_o,
  input  logic [7:0]            src_dat_i,
  input  logic                  src_ack_i,
  input  logic                  src_stall_i,
  input  logic                  snk_cyc_i,
  input  logic                  snk_stb_i,
  input  logic                  snk_we_i,
  output logic [7:0]            snk_dat_o,
  output logic                  snk_ack_o,
  output logic                  snk_err_o,
  output logic                  snk_stall_o,
  output logic [ADDR_WIDTH:0]   level_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW:0]           inflight;
  wb_resp_e              resp_q, resp_d;
  byte_t                 dat_q, dat_d;
  byte_t                 mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  req, issue, ack_ok, pop;

  always_comb begin
    // Sum is one bit wider so count + outstanding can reach DEPTH without wrapping.
    inflight    = {1'b0, count_q} + {1'b0, outst_q};
    src_stb_o   = fetch_en_i && (inflight < (CW + 1)'(DEPTH));
    src_cyc_o   = src_stb_o || (outst_q != '0);
    src_we_o    = 1'b0;
    issue       = src_stb_o && !src_stall_i;
    ack_ok      = src_ack_i && (outst_q != '0);
    req         = snk_cyc_i && snk_stb_i;
    snk_stall_o = req && !snk_we_i && (count_q == '0);
    pop         = req && !snk_we_i && (count_q != '0);
  end

  always_comb begin
    count_d = count_q;
    unique case ({ack_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    outst_d = outst_q;
    unique case ({issue, ack_ok})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    resp_d = RESP_NONE;
    if (pop)                  resp_d = RESP_ACK;
    else if (req && snk_we_i) resp_d = RESP_ERR;

    dat_d = dat_q;
    if (pop) dat_d = mem[rd_ptr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      outst_q <= '0;
      resp_q  <= RESP_NONE;
      dat_q   <= '0;
    end else begin
      count_q <= count_d;
      outst_q <= outst_d;
      resp_q  <= resp_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ack_ok) mem[wr_ptr] <= src_dat_i;
  end

  fifo_addr_gen_an #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ack_ok),
    .ptr_o  (wr_ptr)
  );

  fifo_addr_gen_an #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (pop),
    .ptr_o  (rd_ptr)
  );

  assign snk_ack_o = (resp_q == RESP_ACK);
  assign snk_err_o = (resp_q == RESP_ERR);
  assign snk_dat_o = dat_q;
  assign level_o   = count_q;

endmodule

// File: tb/tb_wb_read_fifo.sv
// Bench for wb_read_fifo: directed table, scripted source/consumer sequences and
// randomized traffic checked against a queue-based model.
module tb_wb_read_fifo;
  import wb_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       fetch_en_i = 1'b0;
  logic       src_cyc_o, src_stb_o, src_we_o;
  logic [7:0] src_dat_i = '0;
  logic       src_ack_i = 1'b0;
  logic       src_stall_i = 1'b0;
  logic       snk_cyc_i = 1'b0;
  logic       snk_stb_i = 1'b0;
  logic       snk_we_i = 1'b0;
  logic [7:0] snk_dat_o;
  logic       snk_ack_o, snk_err_o, snk_stall_o;
  logic [4:0] level_o;

  always #5 clk_i = ~clk_i;

  wb_read_fifo #(.ADDR_WIDTH(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .fetch_en_i  (fetch_en_i),
    .src_cyc_o   (src_cyc_o),
    .src_stb_o   (src_stb_o),
    .src_we_o    (src_we_o),
    .src_dat_i   (src_dat_i),
    .src_ack_i   (src_ack_i),
    .src_stall_i (src_stall_i),
    .snk_cyc_i   (snk_cyc_i),
    .snk_stb_i   (snk_stb_i),
    .snk_we_i    (snk_we_i),
    .snk_dat_o   (snk_dat_o),
    .snk_ack_o   (snk_ack_o),
    .snk_err_o   (snk_err_o),
    .snk_stall_o (snk_stall_o),
    .level_o     (level_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: stored bytes as a queue, accepted-but-unacked reads as a number.
  byte_t mq[$];
  int    m_out = 0;
  byte_t m_dat = 8'h00;

  // Scripted source/consumer knobs.
  int    cyc_no = 0;
  int    pend[$];
  int    n_issued = 0;
  int    g_max_issue = 1 << 30;
  int    g_lat = 1;
  int    g_stall = 0;
  bit    g_fe = 0;
  bit    g_rd = 0;
  bit    g_rand = 0;
  byte_t next_dat = 8'h00;
  bit    last_issue;

  task automatic step(input logic fe, input logic ack, input byte_t d, input logic st,
                      input logic cyc, input logic stb, input logic we);
    bit e_stb, e_cyc, e_stall, req, pop, e_err;
    fetch_en_i = fe; src_ack_i = ack; src_dat_i = d; src_stall_i = st;
    snk_cyc_i = cyc; snk_stb_i = stb; snk_we_i = we;
    #1;
    e_stb   = fe && (mq.size() + m_out < DEPTH);
    e_cyc   = e_stb || (m_out != 0);
    req     = cyc && stb;
    e_stall = req && !we && (mq.size() == 0);
    chk("src_stb_o", src_stb_o, e_stb);
    chk("src_cyc_o", src_cyc_o, e_cyc);
    chk("src_we_o", src_we_o, 1'b0);
    chk("snk_stall_o", snk_stall_o, e_stall);
    last_issue = e_stb && !st;
    pop   = req && !we && (mq.size() != 0);
    e_err = req && we;
    if (pop) m_dat = mq.pop_front();
    if (ack && m_out != 0) begin
      mq.push_back(d);
      m_out--;
    end
    if (last_issue) m_out++;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("snk_ack_o", snk_ack_o, pop);
    chk("snk_err_o", snk_err_o, e_err);
    chk("snk_dat_o", snk_dat_o, m_dat);
    chk("level_o", level_o, mq.size());
  endtask

  task automatic cycle();
    logic  ack, fe, st, cyc, stb, we;
    byte_t d;
    ack = (pend.size() != 0) && (pend[0] <= cyc_no);
    if (ack) void'(pend.pop_front());
    else if (g_rand && pend.size() == 0 && $urandom_range(0, 15) == 0) ack = 1'b1;
    d = g_rand ? byte_t'($urandom) : next_dat;
    if (ack && !g_rand) next_dat++;
    fe = g_rand ? ($urandom_range(0, 3) != 0) : (g_fe && n_issued < g_max_issue);
    if (g_rand) st = ($urandom_range(0, 3) == 0);
    else begin
      st = (g_stall > 0);
      if (g_stall > 0) g_stall--;
    end
    if (g_rand) begin
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 15) == 0);
    end else begin
      cyc = g_rd; stb = g_rd; we = 1'b0;
    end
    step(fe, ack, d, st, cyc, stb, we);
    if (last_issue) begin
      pend.push_back(cyc_no + (g_rand ? int'($urandom_range(1, 3)) : g_lat));
      n_issued++;
    end
    cyc_no++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asserted at a falling edge; outputs must clear without waiting for a clock.
  task automatic do_reset(input string nm);
    fetch_en_i = 1'b0; snk_cyc_i = 1'b0; snk_stb_i = 1'b0; snk_we_i = 1'b0;
    src_ack_i = 1'b0; src_stall_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk({nm, "_src_cyc"}, src_cyc_o, 1'b0);
    chk({nm, "_src_stb"}, src_stb_o, 1'b0);
    chk({nm, "_ack"}, snk_ack_o, 1'b0);
    chk({nm, "_err"}, snk_err_o, 1'b0);
    chk({nm, "_dat"}, snk_dat_o, 8'h00);
    chk({nm, "_level"}, level_o, 5'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc_no++;
    mq.delete();
    m_out = 0;
    m_dat = 8'h00;
    next_dat = 8'h00;
    g_fe = 0; g_rd = 0; g_stall = 0; g_lat = 1; g_max_issue = 1 << 30;
  endtask

  typedef struct packed {
    logic [5:0] in_bits;   // {fetch_en, ack, stall, cyc, stb, we}
    byte_t      dat;
    logic [4:0] exp_bits;  // {src_stb, src_cyc, snk_stall, snk_ack, snk_err}
    byte_t      e_dat;
    logic [4:0] e_lvl;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{6'b000000, 8'h00, 5'b00000, 8'h00, 5'd0};
    tbl[1] = '{6'b000110, 8'h00, 5'b00100, 8'h00, 5'd0};
    tbl[2] = '{6'b101000, 8'h00, 5'b11000, 8'h00, 5'd0};
    tbl[3] = '{6'b100000, 8'h00, 5'b11000, 8'h00, 5'd0};
    tbl[4] = '{6'b010000, 8'h5A, 5'b01000, 8'h00, 5'd1};
    tbl[5] = '{6'b010000, 8'h77, 5'b00000, 8'h00, 5'd1};
    tbl[6] = '{6'b000111, 8'h00, 5'b00001, 8'h00, 5'd1};
    tbl[7] = '{6'b000110, 8'h00, 5'b00010, 8'h5A, 5'd0};
    tbl[8] = '{6'b000000, 8'h00, 5'b00000, 8'h5A, 5'd0};

    @(negedge clk_i);
    do_reset("rst0");

    for (int i = 0; i < 9; i++) begin
      {fetch_en_i, src_ack_i, src_stall_i, snk_cyc_i, snk_stb_i, snk_we_i} = tbl[i].in_bits;
      src_dat_i = tbl[i].dat;
      #1;
      chk($sformatf("tbl%0d_src_stb", i), src_stb_o, tbl[i].exp_bits[4]);
      chk($sformatf("tbl%0d_src_cyc", i), src_cyc_o, tbl[i].exp_bits[3]);
      chk($sformatf("tbl%0d_stall", i), snk_stall_o, tbl[i].exp_bits[2]);
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("tbl%0d_ack", i), snk_ack_o, tbl[i].exp_bits[1]);
      chk($sformatf("tbl%0d_err", i), snk_err_o, tbl[i].exp_bits[0]);
      chk($sformatf("tbl%0d_dat", i), snk_dat_o, tbl[i].e_dat);
      chk($sformatf("tbl%0d_level", i), level_o, tbl[i].e_lvl);
    end

    // Fill to DEPTH with single-cycle acks, then drain 16 plus one stalled read.
    do_reset("rst1");
    g_fe = 1; g_lat = 1;
    run(22);
    chk("fill_level", level_o, 5'd16);
    chk("fill_stb_low", src_stb_o, 1'b0);
    g_fe = 0; g_rd = 1;
    run(17);
    chk("drain_level", level_o, 5'd0);
    g_rd = 0;

    // Stall three cycles, then four reads in flight with long ack latency.
    do_reset("rst2");
    g_fe = 1; g_stall = 3; g_lat = 4; g_max_issue = n_issued + 4;
    run(12);
    chk("stall_level", level_o, 5'd4);

    // Steady state at level 8: ack, issue and pop every cycle; pointers wrap.
    do_reset("rst3");
    g_fe = 1; g_lat = 1;
    run(9);
    g_rd = 1;
    run(40);
    chk("steady_level", level_o, 5'd8);

    // Consumer write at level 3 gives an error and leaves the level alone.
    do_reset("rst4");
    g_fe = 1; g_lat = 1; g_max_issue = n_issued + 3;
    run(4);
    step(1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("wr_err_level", level_o, 5'd3);

    // Reset mid-burst with two outstanding; late acks afterwards are ignored.
    do_reset("rst5");
    g_fe = 1; g_lat = 3; g_max_issue = n_issued + 2;
    run(2);
    do_reset("rst_mid");
    run(5);
    chk("post_rst_level", level_o, 5'd0);

    // Randomized traffic against the model.
    pend.delete();
    g_rand = 1;
    run(1500);
    g_rand = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
